// File: rtl/rca_seq_pkg.sv
// Shared definitions for the multi-cycle ripple-carry add/subtract sequencer.
// Holds the FSM state encoding and the default operand/slice widths.
package rca_seq_pkg;

   localparam int DATA_W_DEF  = 64;
   localparam int SLICE_W_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/rca_slice.sv
// Purely combinational SLICE_W-bit ripple-carry adder built from full-adder
// cells.
// Ports:
//   x, y  : slice operands
//   ci    : carry into bit 0
//   sum   : slice sum
//   co    : carry out of the top bit
module rca_slice #(
   parameter int SLICE_W = rca_seq_pkg::SLICE_W_DEF
) (
   input  logic [SLICE_W-1:0] x,
   input  logic [SLICE_W-1:0] y,
   input  logic               ci,
   output logic [SLICE_W-1:0] sum,
   output logic               co
);

   logic [SLICE_W:0] c;

   assign c[0] = ci;

   for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
      assign sum[i]  = x[i] ^ y[i] ^ c[i];
      assign c[i+1]  = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
   end

   assign co = c[SLICE_W];

endmodule

// File: rtl/rca_slice_sequencer.sv
// Multi-cycle DATA_W-bit add/subtract unit that reuses one SLICE_W-bit
// ripple-carry slice for DATA_W/SLICE_W cycles, with the inter-slice carry
// held in a register.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake (ready only in IDLE)
//   a, b, cin, sub        : operands; sub=1 computes a-b and ignores cin
//   out_valid / out_ready : result handshake (valid only in DONE)
//   s, cout, ovf          : result, MSB carry-out, signed overflow
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for operands, in_ready=1
// ST_RUN  | one slice per cycle, slice index k counts up
// ST_DONE | result presented with out_valid=1 until out_ready
module rca_slice_sequencer
   import rca_seq_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int SLICE_W = SLICE_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              cin,
   input  logic              sub,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] s,
   output logic              cout,
   output logic              ovf
);

   localparam int NUM_SLICES = DATA_W / SLICE_W;
   localparam int KW         = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

   if ((DATA_W % SLICE_W) != 0 || DATA_W < SLICE_W) begin : g_bad_width
      $error("rca_slice_sequencer: DATA_W must be a positive multiple of SLICE_W");
   end

   state_t              state_q, state_d;
   logic [KW-1:0]       k_q;
   logic [DATA_W-1:0]   a_q, b_q, s_q;
   logic                carry_q, cout_q, ovf_q;

   logic [SLICE_W-1:0]  slice_x, slice_y, slice_sum;
   logic                slice_co;
   logic                last_slice;
   logic                accept;

   assign in_ready   = (state_q == ST_IDLE);
   assign out_valid  = (state_q == ST_DONE);
   assign accept     = in_valid && in_ready;
   assign last_slice = (k_q == KW'(NUM_SLICES - 1));

   assign slice_x = a_q[k_q*SLICE_W +: SLICE_W];
   assign slice_y = b_q[k_q*SLICE_W +: SLICE_W];

   rca_slice #(
      .SLICE_W (SLICE_W)
   ) u_slice (
      .x   (slice_x),
      .y   (slice_y),
      .ci  (carry_q),
      .sum (slice_sum),
      .co  (slice_co)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept)     state_d = ST_RUN;
         ST_RUN:  if (last_slice) state_d = ST_DONE;
         ST_DONE: if (out_ready)  state_d = ST_IDLE;
         default:                 state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         k_q     <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  a_q     <= a;
                  // Subtraction as a + ~b + 1: invert b here, force carry-in.
                  b_q     <= sub ? ~b : b;
                  carry_q <= sub ? 1'b1 : cin;
                  k_q     <= '0;
               end
            end
            ST_RUN: begin
               s_q[k_q*SLICE_W +: SLICE_W] <= slice_sum;
               carry_q <= slice_co;
               k_q     <= k_q + 1'b1;
               if (last_slice) begin
                  cout_q <= slice_co;
                  // Operand and sum MSBs xor'd recover the carry into the MSB.
                  ovf_q  <= a_q[DATA_W-1] ^ b_q[DATA_W-1] ^
                            slice_sum[SLICE_W-1] ^ slice_co;
               end
            end
            default: ;
         endcase
      end
   end

   assign s    = s_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule
